// File: rtl/pc_branch_unit.sv
// Next-PC generator: sequential and branch/jump targets, with stall freeze
// and a one-deep redirect latch that is applied when the stall releases.
module pc_branch_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      OFFSET_WIDTH = 8,
    parameter int unsigned      OFFSET_SHIFT = 2,
    parameter int unsigned      STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    BUSYWAIT,
    input  logic                    BEQ,
    input  logic                    BNE,
    input  logic                    JUMP,
    input  logic                    ZERO,
    input  logic [OFFSET_WIDTH-1:0] OFFSET,
    output logic [WIDTH-1:0]        PC,
    output logic [WIDTH-1:0]        PC_SEQ,
    output logic                    TAKEN,
    output logic                    REDIRECT_PENDING
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HOLD      = 2'd1,
        HOLD_PEND = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] offset_ext;
    logic [WIDTH-1:0] target;
    logic             take;

    // Offset is sign-extended to the PC width before scaling to bytes.
    assign offset_ext = WIDTH'($signed(OFFSET)) << OFFSET_SHIFT;
    assign PC_SEQ     = PC + WIDTH'(STEP);
    assign target     = PC_SEQ + offset_ext;
    assign take       = JUMP | (BEQ & ZERO) | (BNE & ~ZERO);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state            <= RUN;
            PC               <= RESET_PC;
            pending          <= '0;
            TAKEN            <= 1'b0;
            REDIRECT_PENDING <= 1'b0;
        end else begin
            case (state)
                RUN, HOLD: begin
                    if (!BUSYWAIT) begin
                        PC               <= take ? target : PC_SEQ;
                        TAKEN            <= take;
                        REDIRECT_PENDING <= 1'b0;
                        state            <= RUN;
                    end else if (take) begin
                        pending          <= target;
                        REDIRECT_PENDING <= 1'b1;
                        state            <= HOLD_PEND;
                    end else begin
                        state            <= HOLD;
                    end
                end
                HOLD_PEND: begin
                    // The stalled instruction is unchanged, so a new take is ignored.
                    if (!BUSYWAIT) begin
                        PC               <= pending;
                        TAKEN            <= 1'b1;
                        REDIRECT_PENDING <= 1'b0;
                        state            <= RUN;
                    end
                end
                default: begin
                    REDIRECT_PENDING <= 1'b0;
                    state            <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: two instances (default and wrap-around reset PC)
// driven in lockstep and compared against a transaction-level model.
module tb_pc_branch_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        BUSYWAIT = 1'b0;
    logic        BEQ = 1'b0;
    logic        BNE = 1'b0;
    logic        JUMP = 1'b0;
    logic        ZERO = 1'b0;
    logic [7:0]  OFFSET = 8'h00;

    logic [31:0] pc_a, seq_a, pc_w, seq_w;
    logic        tk_a, rp_a, tk_w, rp_w;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per instance: 0 = default, 1 = RESET_PC 32'hFFFFFFFC
    logic [31:0] m_pc   [2];
    logic [31:0] m_pend [2];
    logic        m_tk   [2];
    logic        m_pv   [2];
    logic [31:0] m_rst  [2];

    always #5 CLK = ~CLK;

    pc_branch_unit dut (
        .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT), .BEQ(BEQ), .BNE(BNE),
        .JUMP(JUMP), .ZERO(ZERO), .OFFSET(OFFSET),
        .PC(pc_a), .PC_SEQ(seq_a), .TAKEN(tk_a), .REDIRECT_PENDING(rp_a)
    );

    pc_branch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT), .BEQ(BEQ), .BNE(BNE),
        .JUMP(JUMP), .ZERO(ZERO), .OFFSET(OFFSET),
        .PC(pc_w), .PC_SEQ(seq_w), .TAKEN(tk_w), .REDIRECT_PENDING(rp_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i]   = m_rst[i];
            m_pend[i] = '0;
            m_tk[i]   = 1'b0;
            m_pv[i]   = 1'b0;
        end
    endtask

    // One clock edge of the architectural behaviour, from current inputs.
    task automatic model_edge();
        logic        tk;
        logic [31:0] tgt;
        tk = JUMP | (BEQ & ZERO) | (BNE & !ZERO);
        for (int i = 0; i < 2; i++) begin
            tgt = m_pc[i] + 32'd4 + 32'(int'($signed(OFFSET)) * 4);
            if (BUSYWAIT) begin
                if (!m_pv[i] && tk) begin
                    m_pend[i] = tgt;
                    m_pv[i]   = 1'b1;
                end
            end else if (m_pv[i]) begin
                m_pc[i] = m_pend[i];
                m_tk[i] = 1'b1;
                m_pv[i] = 1'b0;
            end else begin
                m_pc[i] = tk ? tgt : m_pc[i] + 32'd4;
                m_tk[i] = tk;
            end
        end
    endtask

    task automatic check_all();
        check("pc_a",     pc_a,        m_pc[0]);
        check("seq_a",    seq_a,       m_pc[0] + 32'd4);
        check("taken_a",  32'(tk_a),   32'(m_tk[0]));
        check("pend_a",   32'(rp_a),   32'(m_pv[0]));
        check("pc_w",     pc_w,        m_pc[1]);
        check("seq_w",    seq_w,       m_pc[1] + 32'd4);
        check("taken_w",  32'(tk_w),   32'(m_tk[1]));
        check("pend_w",   32'(rp_w),   32'(m_pv[1]));
    endtask

    task automatic drive(input logic bw, input logic beq, input logic bne,
                         input logic jmp, input logic z, input logic [7:0] off);
        BUSYWAIT = bw; BEQ = beq; BNE = bne; JUMP = jmp; ZERO = z; OFFSET = off;
    endtask

    // Apply inputs, advance one edge, then sample 1 time unit after it.
    task automatic cycle(input logic bw, input logic beq, input logic bne,
                         input logic jmp, input logic z, input logic [7:0] off);
        drive(bw, beq, bne, jmp, z, off);
        model_edge();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    // Asynchronous reset between edges, released on a falling edge.
    task automatic do_reset();
        RESET = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge CLK);
        RESET = 1'b1;
        drive(0, 0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        m_rst[0] = 32'h0000_0000;
        m_rst[1] = 32'hFFFF_FFFC;
        @(posedge CLK);
        #1;
        do_reset();
        check("rst_pc_a", pc_a, 32'h0);
        check("rst_pc_w", pc_w, 32'hFFFF_FFFC);

        // Wrap-around on the second instance
        cycle(0, 0, 0, 0, 0, 8'h00);
        check("wrap_seq", pc_w, 32'h0);
        cycle(0, 0, 0, 1, 0, 8'h80);
        check("wrap_jump", pc_w, 32'hFFFF_FE04);
        check("neg_jump_a", pc_a, 32'hFFFF_FE08);

        // Sequential run after reset
        do_reset();
        cycle(0, 0, 0, 0, 0, 8'h00);
        cycle(0, 0, 0, 0, 0, 8'h00);
        cycle(0, 0, 0, 0, 0, 8'h00);
        check("seq_12", pc_a, 32'd12);
        check("seq_tk", 32'(tk_a), 32'd0);

        // BEQ taken backwards, then plain step
        cycle(0, 1, 0, 0, 1, 8'hFE);
        check("beq_pc", pc_a, 32'd8);
        check("beq_tk", 32'(tk_a), 32'd1);
        cycle(0, 0, 0, 0, 0, 8'h00);
        check("after_beq", pc_a, 32'd12);
        check("after_beq_tk", 32'(tk_a), 32'd0);

        // BNE not taken, then taken
        cycle(0, 0, 1, 0, 1, 8'h05);
        check("bne_nt", pc_a, 32'd16);
        cycle(0, 0, 1, 0, 0, 8'h05);
        check("bne_t", pc_a, 32'd40);

        // Jump back to 8, then stall with a redirect in the first stalled cycle
        cycle(0, 0, 0, 1, 0, 8'hF7);
        check("jump_8", pc_a, 32'd8);
        cycle(1, 0, 0, 1, 0, 8'h03);
        check("stall1_pc", pc_a, 32'd8);
        check("stall1_rp", 32'(rp_a), 32'd1);
        cycle(1, 0, 0, 1, 0, 8'h40);
        cycle(1, 0, 0, 0, 0, 8'h00);
        check("stall3_pc", pc_a, 32'd8);
        check("stall3_rp", 32'(rp_a), 32'd1);
        cycle(0, 0, 0, 0, 0, 8'h00);
        check("release_pc", pc_a, 32'd24);
        check("release_tk", 32'(tk_a), 32'd1);
        check("release_rp", 32'(rp_a), 32'd0);

        // Reset while a redirect is pending discards it
        cycle(1, 0, 0, 1, 0, 8'h10);
        check("pend_pre_rst", 32'(rp_a), 32'd1);
        do_reset();
        check("rst_pend", 32'(rp_a), 32'd0);
        check("rst_pend_pc", pc_a, 32'd0);
        cycle(0, 0, 0, 0, 0, 8'h00);
        check("post_rst_pc", pc_a, 32'd4);
        check("post_rst_pc_w", pc_w, 32'd0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 9) < 4), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 4) == 0), 1'($urandom), 8'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
Parametrised next-PC generator for the CPU datapath; successor to the fixed 32-bit signed target-offset adder.
- Holds the program counter and computes sequential and branch/jump targets with configurable width, offset width, offset scaling and PC step.
- Supports BEQ and BNE conditions.
- Freezes the PC while memory asserts BUSYWAIT, and latches a redirect that arrives during a stall so it is applied on release.

Parameters:
WIDTH, 32, PC/address width in bits
OFFSET_WIDTH, 8, width of signed instruction offset field (word units)
OFFSET_SHIFT, 2, left shift applied to sign-extended offset (bytes per word = 2^OFFSET_SHIFT)
STEP, 4, sequential PC increment
RESET_PC, 0, PC value loaded on reset

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-low reset
BUSYWAIT  input  1  memory stall; PC frozen while high
BEQ  input  1  branch-if-equal instruction in decode
BNE  input  1  branch-if-not-equal instruction in decode
JUMP  input  1  unconditional jump instruction in decode
ZERO  input  1  ALU zero flag
OFFSET  input  OFFSET_WIDTH  signed word offset from instruction
PC  output  WIDTH  current program counter (registered)
PC_SEQ  output  WIDTH  PC + STEP (combinational)
TAKEN  output  1  registered; 1 if the last PC update was a redirect
REDIRECT_PENDING  output  1  registered; redirect latched during a stall, not yet applied

Behaviour:
- Arithmetic:
  - target = PC + STEP + (sign_extend(OFFSET) << OFFSET_SHIFT).
  - All sums are modulo 2^WIDTH; no overflow flag; wrap-around is silent.
- take = JUMP | (BEQ & ZERO) | (BNE & ~ZERO). Simultaneous BEQ and BNE is illegal input; the OR result is used, with no further checking.
- Reset (RESET low, asynchronous, immediate): PC=RESET_PC, TAKEN=0, REDIRECT_PENDING=0, internal pending target=0, state=RUN. A reset mid-stall discards any pending redirect.
- States: RUN, HOLD, HOLD_PEND. REDIRECT_PENDING=1 exactly in HOLD_PEND.
- RUN, BUSYWAIT=0 at edge: PC <= take ? target : PC_SEQ; TAKEN <= take; stay RUN.
- RUN, BUSYWAIT=1 at edge: PC held, TAKEN held.
  - take=1: latch target into pending register -> HOLD_PEND.
  - Otherwise -> HOLD.
- HOLD, BUSYWAIT=1:
  - take=1: latch target -> HOLD_PEND.
  - Otherwise stay HOLD.
  - PC held.
- HOLD, BUSYWAIT=0: identical to RUN with BUSYWAIT=0 -> RUN.
- HOLD_PEND, BUSYWAIT=1:
  - PC held; pending register not overwritten.
  - Further take ignored, since the stalled instruction is unchanged.
- HOLD_PEND, BUSYWAIT=0: PC <= pending target regardless of current take; TAKEN <= 1 -> RUN.
- Latency:
  - One edge from a non-stalled decision to the PC update.
  - A stalled redirect is applied on the first edge with BUSYWAIT=0.
- PC_SEQ always tracks the current PC combinationally.

Test Plan:
1. Defaults; RESET low then high, 3 clocks with no control inputs -> PC=0 after reset, then 4, 8, 12; TAKEN=0.
2. PC=12, BEQ=1, ZERO=1, OFFSET=8'hFE (-2), one clock -> PC=8, TAKEN=1. Next clock with controls low -> PC=12, TAKEN=0.
3. PC=12, BNE=1, ZERO=1, OFFSET=8'h05 -> not taken, PC=16, TAKEN=0. Repeat with ZERO=0 -> PC=16+4+20=40, TAKEN=1.
4. Stall redirect:
   - PC=8, BUSYWAIT=1 for 3 clocks; JUMP=1, OFFSET=3 only in the first stalled cycle -> PC stays 8, REDIRECT_PENDING=1 for all 3 stalled cycles.
   - BUSYWAIT drops -> PC=24, TAKEN=1, REDIRECT_PENDING=0.
5. Wrap:
   - RESET_PC=32'hFFFFFFFC, one clock with no branch -> PC=0.
   - JUMP=1, OFFSET=8'h80 (-128) -> PC=32'hFFFFFE04.
6. Reset during HOLD_PEND (BUSYWAIT=1, pending latched), RESET low between edges -> PC=RESET_PC and REDIRECT_PENDING=0 immediately. After RESET high and BUSYWAIT=0 -> PC=RESET_PC+4, no redirect applied.
